// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder sitting at the far end of the CPU's MemRead/MemWrite
// interface. It accepts one load/store request at a time over a valid/ready
// handshake. After WAIT_CYCLES edges it performs a word or byte access on an
// internal word array. It then returns read data or a store acknowledge over
// a second valid/ready handshake.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request (IDLE only)
//   req_write   in   1   1 = store, 0 = load
//   req_byte    in   1   1 = byte access, 0 = word access
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data (byte store uses [7:0])
//   resp_valid  out  1   response present (RESP only)
//   resp_ready  in   1   requester takes the response
//   resp_rdata  out  32  load data; 0 for stores and on error
//   resp_err    out  1   access was misaligned or out of range
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2     // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // First illegal byte address; 33 bits so DEPTH_WORDS*4 cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [3:0]          r_cnt;
    logic                r_write;
    logic                r_byte;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_access;
    logic                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_word;
    logic [7:0]          w_lane_byte;
    logic [31:0]         w_load;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && req_valid;
    // The access happens on the last WAIT edge, i.e. the one entering RESP.
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd1);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid)         w_next = S_WAIT;
            S_WAIT: if (r_cnt == 4'd1)     w_next = S_RESP;
            S_RESP: if (resp_ready)        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // ------------------------------------------------------------------
    // Access decode on the latched request
    // ------------------------------------------------------------------
    assign w_err = (!r_byte && (r_addr[1:0] != 2'b00)) ||
                   ({1'b0, r_addr} >= ADDR_LIMIT);

    // Only meaningful when w_err is low; the error path masks everything else.
    assign w_idx       = r_addr[IDX_W+1:2];
    assign w_word      = r_mem[w_idx];
    assign w_lane_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_load      = r_byte ? {{24{w_lane_byte[7]}}, w_lane_byte} : w_word;

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt   <= r_cnt - 4'd1;
            end

            // rdata/err keep their values after the handshake until the
            // next access overwrites them.
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array is cleared by the asynchronous reset, so it is built
    // from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_access && r_write && !w_err) begin
            if (r_byte) begin
                r_mem[w_idx][{r_addr[1:0], 3'b000} +: 8] <= r_wdata[7:0];
            end else begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

endmodule
